amplitude_window_scheduler: RTL and testbench
=============================================

Name: amplitude_window_scheduler

Overview:
- Sequences the global min/max amplitude datapath into fixed-length analysis windows.
- Accepts the 16-bit signed sample stream and clears/seeds a min/max tracker at each window start.
- At window end it reports min, max, peak-to-peak and sample count to a downstream consumer through a valid/ready handshake.
- Sits between the audio sample source and the level-metering/report logic; applies backpressure to the source while a result is pending.

Parameters:
- DATA_W, 16, sample width in bits (two's complement).
- CNT_W, 16, width of window_len and the sample counter.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  reset; one clock; reset is asynchronous and active-low.
- enable  in  1  run request; low aborts any partial window.
- window_len  in  CNT_W  samples per window; latched at each window start; 0 treated as 1.
- flush  in  1  single-cycle request to report the current partial window early.
- sample_in  in  DATA_W  signed sample.
- sample_valid  in  1  sample_in is valid.
- sample_ready  out  1  block accepts a sample this cycle; accept = sample_valid & sample_ready.
- res_valid  out  1  result registers hold an unconsumed result.
- res_ready  in  1  consumer takes the result; transfer = res_valid & res_ready.
- res_min  out  DATA_W  signed window minimum.
- res_max  out  DATA_W  signed window maximum.
- res_p2p  out  DATA_W+1  unsigned res_max - res_min.
- res_count  out  CNT_W  number of samples in the reported window.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (rst low, asynchronous): state IDLE; sample_ready, res_valid and busy are 0; res_min, res_max, res_p2p and res_count are 0; counter and tracker are cleared. Asserting reset in any state, including REPORT, drops res_valid immediately.
- States:
  - IDLE: sample_ready=0. When enable=1, go to ACCUM; latch len = max(window_len, 1); count=0; tracker empty.
  - ACCUM: sample_ready=1.
    - On accept with count=0, the sample seeds both min and max. There is no sentinel value.
    - On later accepts, min = smaller of (min, sample) and max = larger of (max, sample), using signed compare. count increments.
    - If an accept makes count+1 == len, go to REPORT at that same edge.
    - If flush=1 and (count>0 or an accept occurs this cycle), go to REPORT at that same edge. A sample accepted in the flush cycle is included in the result.
    - flush with count=0 and no accept is ignored.
    - If enable=0, go to IDLE: the partial window is discarded and no result is produced. enable low takes priority over accept and flush in the same cycle.
  - REPORT: sample_ready=0. res_valid=1, with res_* loaded at the entry edge using the final merged values.
    - On transfer: clear the tracker and count=0, then return to ACCUM if enable=1 (re-latch len from window_len) or to IDLE if enable=0.
    - enable dropping while in REPORT does not withdraw the result.
- Latency: res_valid rises on the same edge that accepts the last sample of the window. sample_ready returns on the edge after the transfer, so there is a minimum 1-cycle gap between windows.
- res_* stay stable while res_valid=1 and res_ready=0.
- Arithmetic:
  - res_p2p = sign-extended res_max minus sign-extended res_min at DATA_W+1 bits; the result is always >= 0.
  - Extreme case: 32767 - (-32768) = 65535.
- Counter never wraps: len <= 2^CNT_W - 1, and reaching len forces REPORT.
- window_len changes mid-window are ignored until the next window start.

Decomposition:
- Shared package (amplitude_pkg):
  - DATA_W default.
  - State enum: IDLE, ACCUM, REPORT.
  - Width-derived constant for the p2p width (DATA_W+1).
- Sub-module minmax_tracker:
  - Holds the min/max registers.
  - Inputs: clear, seed/update strobe, sample.
  - Provides the merged next-value outputs the scheduler needs to register results on the accept edge.
- The scheduler keeps the FSM, counter, handshakes and result registers.

Test Plan:
- Basic window: len=4, samples 10,-3,7,2 with res_ready=1 -> res_valid for 1 cycle with min=-3, max=10, p2p=13, count=4; sample_ready is low for exactly 1 cycle.
- Extremes: len=2, samples -32768, 32767 -> min=-32768, max=32767, p2p=65535.
- Backpressure: len=2, samples 4,-4, res_ready held low 5 cycles -> sample_ready=0 and res_* stable throughout. Then res_ready=1, next samples 100,200 -> min=100, max=200 (no carry-over from the previous window).
- Flush: len=8, samples 5,5,-1, then flush -> count=3, min=-1, max=5, p2p=6. Flush with count=0 -> no res_valid.
- Abort and reset: enable low after 2 of 4 samples -> IDLE, no result. Re-enable, feed 1,2,3,4 -> min=1, max=4, count=4. Assert rst low during REPORT -> res_valid=0 asynchronously, busy=0.
- Degenerate length: window_len=0 and samples 7, -9 -> two results, each count=1 with min=max=sample and p2p=0.

Source files
------------

// File: rtl/amplitude_pkg.sv
// Shared types and width helpers for the amplitude window scheduler.
package amplitude_pkg;
    localparam int DEF_DATA_W = 16;
    localparam int DEF_CNT_W  = 16;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        REPORT
    } state_t;

    // Peak-to-peak needs one extra bit so max - min never overflows.
    function automatic int p2p_width(input int data_w);
        return data_w + 1;
    endfunction
endpackage

// File: rtl/minmax_tracker.sv
// Running signed min/max of the current window; exposes the merged next values
// so the scheduler can register a result on the same edge as the last sample.
module minmax_tracker #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              update,
    input  logic              seed,
    input  logic [DATA_W-1:0] sample,
    output logic [DATA_W-1:0] cur_min,
    output logic [DATA_W-1:0] cur_max,
    output logic [DATA_W-1:0] nxt_min,
    output logic [DATA_W-1:0] nxt_max
);
    always_comb begin
        nxt_min = cur_min;
        nxt_max = cur_max;
        if (seed) begin
            // First sample of a window defines both extremes; no sentinel needed.
            nxt_min = sample;
            nxt_max = sample;
        end else begin
            if ($signed(sample) < $signed(cur_min)) nxt_min = sample;
            if ($signed(sample) > $signed(cur_max)) nxt_max = sample;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur_min <= '0;
            cur_max <= '0;
        end else if (clear) begin
            cur_min <= '0;
            cur_max <= '0;
        end else if (update) begin
            cur_min <= nxt_min;
            cur_max <= nxt_max;
        end
    end
endmodule

// File: rtl/amplitude_window_scheduler.sv
// Cuts the sample stream into fixed-length windows and reports min/max/p2p/count
// through a valid/ready result port, stalling the source while a result is pending.
module amplitude_window_scheduler
    import amplitude_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enable,
    input  logic [CNT_W-1:0]             window_len,
    input  logic                         flush,
    input  logic [DATA_W-1:0]            sample_in,
    input  logic                         sample_valid,
    output logic                         sample_ready,
    output logic                         res_valid,
    input  logic                         res_ready,
    output logic [DATA_W-1:0]            res_min,
    output logic [DATA_W-1:0]            res_max,
    output logic [p2p_width(DATA_W)-1:0] res_p2p,
    output logic [CNT_W-1:0]             res_count,
    output logic                         busy
);
    localparam int P2P_W = p2p_width(DATA_W);

    state_t            state;
    logic [CNT_W-1:0]  len;
    logic [CNT_W-1:0]  count;
    logic [CNT_W:0]    cnt_p1;
    logic [CNT_W-1:0]  len_in;
    logic              accept;
    logic              last;
    logic              go_report;
    logic              trk_clear;
    logic              trk_update;
    logic [DATA_W-1:0] cur_min, cur_max, nxt_min, nxt_max;
    logic [DATA_W-1:0] fin_min, fin_max;
    logic [P2P_W-1:0]  fin_p2p;

    assign accept    = sample_valid & sample_ready;
    assign cnt_p1    = {1'b0, count} + (CNT_W+1)'(1);
    assign last      = (cnt_p1 == {1'b0, len});
    assign len_in    = (window_len == '0) ? CNT_W'(1) : window_len;
    assign go_report = (accept && (last || flush)) || (flush && count != '0);

    assign trk_clear  = (state == IDLE) || (state == ACCUM && !enable) ||
                        (state == REPORT && res_ready);
    assign trk_update = (state == ACCUM) && enable && accept;

    minmax_tracker #(.DATA_W(DATA_W)) u_trk (
        .clk     (clk),
        .rst     (rst),
        .clear   (trk_clear),
        .update  (trk_update),
        .seed    (count == '0),
        .sample  (sample_in),
        .cur_min (cur_min),
        .cur_max (cur_max),
        .nxt_min (nxt_min),
        .nxt_max (nxt_max)
    );

    // A sample accepted in the closing cycle is folded into the reported values.
    assign fin_min = accept ? nxt_min : cur_min;
    assign fin_max = accept ? nxt_max : cur_max;
    assign fin_p2p = {fin_max[DATA_W-1], fin_max} - {fin_min[DATA_W-1], fin_min};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            sample_ready <= 1'b0;
            res_valid    <= 1'b0;
            busy         <= 1'b0;
            len          <= '0;
            count        <= '0;
            res_min      <= '0;
            res_max      <= '0;
            res_p2p      <= '0;
            res_count    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (enable) begin
                        state        <= ACCUM;
                        sample_ready <= 1'b1;
                        busy         <= 1'b1;
                        len          <= len_in;
                        count        <= '0;
                    end
                end
                ACCUM: begin
                    if (!enable) begin
                        state        <= IDLE;
                        sample_ready <= 1'b0;
                        busy         <= 1'b0;
                        count        <= '0;
                    end else if (go_report) begin
                        state        <= REPORT;
                        sample_ready <= 1'b0;
                        res_valid    <= 1'b1;
                        res_min      <= fin_min;
                        res_max      <= fin_max;
                        res_p2p      <= fin_p2p;
                        res_count    <= accept ? cnt_p1[CNT_W-1:0] : count;
                    end else if (accept) begin
                        count <= cnt_p1[CNT_W-1:0];
                    end
                end
                REPORT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        count     <= '0;
                        if (enable) begin
                            state        <= ACCUM;
                            sample_ready <= 1'b1;
                            len          <= len_in;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state        <= IDLE;
                    sample_ready <= 1'b0;
                    res_valid    <= 1'b0;
                    busy         <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_amplitude_window_scheduler.sv
// Directed scoreboard bench for amplitude_window_scheduler.
module tb_amplitude_window_scheduler;
    logic        clk = 1'b0;
    logic        rst;
    logic        enable = 1'b0;
    logic [15:0] window_len = '0;
    logic        flush = 1'b0;
    logic [15:0] sample_in = '0;
    logic        sample_valid = 1'b0;
    logic        sample_ready;
    logic        res_valid;
    logic        res_ready = 1'b1;
    logic [15:0] res_min;
    logic [15:0] res_max;
    logic [16:0] res_p2p;
    logic [15:0] res_count;
    logic        busy;

    amplitude_window_scheduler #(.DATA_W(16), .CNT_W(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .window_len   (window_len),
        .flush        (flush),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_min      (res_min),
        .res_max      (res_max),
        .res_p2p      (res_p2p),
        .res_count    (res_count),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int mn;
        int mx;
        int p2p;
        int cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input int mn, input int mx, input int p2p, input int cnt);
        exp_t e;
        e.mn = mn; e.mx = mx; e.p2p = p2p; e.cnt = cnt;
        exp_q.push_back(e);
    endtask

    // Monitor: every result transfer is checked against the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst === 1'b1 && res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_result: got min %0d max %0d count %0d expected none",
                         $signed(res_min), $signed(res_max), res_count);
            end else begin
                e = exp_q.pop_front();
                chk("res_min", $signed(res_min), e.mn);
                chk("res_max", $signed(res_max), e.mx);
                chk("res_p2p", int'(res_p2p), e.p2p);
                chk("res_count", int'(res_count), e.cnt);
            end
        end
    end

    task automatic send(input int v);
        int t = 0;
        sample_in    = 16'(v);
        sample_valid = 1'b1;
        @(negedge clk);
        while (!sample_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!sample_ready) begin
            n_cmp++;
            n_err++;
            $display("FAIL send_timeout: got sample_ready 0 expected 1 for sample %0d", v);
        end
        @(posedge clk);
        #1;
        sample_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic start_window(input int len);
        drain();
        enable = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        window_len = 16'(len);
        enable     = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_sample_ready", int'(sample_ready), 0);
        chk("rst_res_valid", int'(res_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_res_min", int'(res_min), 0);
        chk("rst_res_max", int'(res_max), 0);
        chk("rst_res_p2p", int'(res_p2p), 0);
        chk("rst_res_count", int'(res_count), 0);
        rst = 1'b1;

        // Basic window, one-cycle result with immediate consume
        start_window(4);
        chk("accum_busy", int'(busy), 1);
        push(-3, 10, 13, 4);
        send(10); send(-3); send(7); send(2);
        chk("basic_ready_low", int'(sample_ready), 0);
        chk("basic_valid_high", int'(res_valid), 1);
        @(posedge clk);
        #1;
        chk("basic_ready_back", int'(sample_ready), 1);
        chk("basic_valid_low", int'(res_valid), 0);

        // Full-scale extremes
        start_window(2);
        push(-32768, 32767, 65535, 2);
        send(-32768); send(32767);

        // Backpressure holds the result and stalls the source
        start_window(2);
        push(-4, 4, 8, 2);
        res_ready = 1'b0;
        send(4); send(-4);
        repeat (5) begin
            @(negedge clk);
            chk("bp_sample_ready", int'(sample_ready), 0);
            chk("bp_res_valid", int'(res_valid), 1);
            chk("bp_res_min", $signed(res_min), -4);
            chk("bp_res_max", $signed(res_max), 4);
            chk("bp_res_p2p", int'(res_p2p), 8);
        end
        res_ready = 1'b1;
        push(100, 200, 100, 2);
        send(100); send(200);

        // Early flush of a partial window
        start_window(8);
        push(-1, 5, 6, 3);
        send(5); send(5); send(-1);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush_valid", int'(res_valid), 1);
        drain();
        @(posedge clk);
        #1;
        // Flush on an empty window is ignored
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush_empty_valid", int'(res_valid), 0);
        chk("flush_empty_ready", int'(sample_ready), 1);
        repeat (3) @(posedge clk);

        // Abort mid-window, then a clean window
        start_window(4);
        send(10); send(20);
        enable = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_ready", int'(sample_ready), 0);
        chk("abort_valid", int'(res_valid), 0);
        enable = 1'b1;
        @(posedge clk);
        #1;
        push(1, 4, 3, 4);
        send(1); send(2); send(3); send(4);

        // window_len = 0 behaves as 1
        start_window(0);
        push(7, 7, 0, 1);
        push(-9, -9, 0, 1);
        send(7); send(-9);

        // Asynchronous reset while a result is pending
        start_window(2);
        res_ready = 1'b0;
        send(1); send(2);
        @(negedge clk);
        chk("pre_rst_valid", int'(res_valid), 1);
        chk("pre_rst_busy", int'(busy), 1);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_valid", int'(res_valid), 0);
        chk("async_rst_busy", int'(busy), 0);
        chk("async_rst_min", int'(res_min), 0);
        chk("async_rst_count", int'(res_count), 0);
        @(posedge clk);
        #1;
        rst       = 1'b1;
        res_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("post_rst_valid", int'(res_valid), 0);
        chk("leftover_expected", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
